// File: rtl/seg_scroll_ctrl.sv
// seg_scroll_ctrl: stores up to MAX_LEN 4-bit symbol codes and slides a
// 6-digit window across them right-to-left, feeding the 7-segment scan driver.
// Latency: data_out is decoded combinationally from the pos/buffer registers;
// writes, clr and start take effect at the next clock edge.
// Backpressure: none. Writes beyond MAX_LEN are dropped (wr_full flags this),
// and wr_en/clr/start are ignored while scrolling.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, wr_data    append one symbol to the buffer (IDLE only)
//   clr               empty the buffer (IDLE only, wins over wr_en)
//   start, stop       begin scrolling (needs msg_len>0) / abort scrolling
//   loop_en           1 = repeat forever, 0 = single pass (sampled at final step)
//   data_out          six digits, [23:20] = leftmost digit
//   busy, done        RUN indicator, one-cycle end-of-pass pulse
//   wr_full, msg_len  buffer status
//   step_pulse        one-cycle pulse on every window advance
module seg_scroll_ctrl #(
   parameter int unsigned STEP_CYCLES = 25000000,
   parameter int unsigned MAX_LEN     = 16,
   parameter int unsigned LEN_W       = 5,
   parameter logic [3:0]  BLANK_CODE  = 4'd5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [3:0]       wr_data,
   input  logic             clr,
   input  logic             start,
   input  logic             stop,
   input  logic             loop_en,
   output logic [23:0]      data_out,
   output logic             busy,
   output logic             done,
   output logic             wr_full,
   output logic [LEN_W-1:0] msg_len,
   output logic             step_pulse
);

   localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   // pos reaches L+6 and a window index reaches L+11, so one extra bit over
   // the length width covers both.
   localparam int unsigned POS_W = LEN_W + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
   localparam logic [POS_W-1:0] LEAD     = POS_W'(6);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             full_q, full_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   logic [3:0]       buf_q [MAX_LEN];
   logic             buf_we;
   logic [AW-1:0]    wr_addr;

   logic             step_hit;
   logic [POS_W-1:0] last_pos;
   logic [POS_W-1:0] v_idx  [6];
   logic [AW-1:0]    v_addr [6];

   assign step_hit = (state_q == RUN) && (cnt_q == CNT_LAST);
   // Last window position: the all-blank frame after the message has left.
   assign last_pos = POS_W'(len_q) + LEAD;
   assign wr_addr  = AW'(len_q);

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      buf_we  = 1'b0;

      case (state_q)
         IDLE: begin
            if (clr) begin
               len_d = '0;
            end else if (wr_en && !full_q) begin
               buf_we = 1'b1;
               len_d  = len_q + LEN_W'(1);
            end
            // stop wins over a simultaneous start
            if (start && !stop && (len_q != '0)) begin
               state_d = RUN;
               pos_d   = '0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               pos_d   = '0;
               cnt_d   = '0;
            end else if (step_hit) begin
               cnt_d = '0;
               if (pos_q == last_pos) begin
                  if (loop_en) begin
                     // position 0 is also all blank; skip it to avoid
                     // showing the blank frame twice in a row
                     pos_d = POS_W'(1);
                  end else begin
                     state_d = IDLE;
                     pos_d   = '0;
                     done_d  = 1'b1;
                  end
               end else begin
                  pos_d = pos_q + POS_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      full_d = (len_d == LEN_MAX);
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         full_q  <= 1'b0;
         pos_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         full_q  <= full_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Symbol storage carries no reset: contents only matter below msg_len.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_q[wr_addr] <= wr_data;
      end
   end

   // ---------------- window decode ----------------
   // Digit k shows virtual position pos+k, where positions 0..5 and
   // L+6..L+11 are blank padding and 6..L+5 map onto the buffer.
   always_comb begin
      data_out = {6{BLANK_CODE}};
      for (int k = 0; k < 6; k++) begin
         v_idx[k]  = '0;
         v_addr[k] = '0;
      end
      if (state_q == RUN) begin
         for (int k = 0; k < 6; k++) begin
            v_idx[k] = pos_q + POS_W'(k);
            if ((v_idx[k] >= LEAD) && (v_idx[k] < last_pos)) begin
               v_addr[k] = AW'(v_idx[k] - LEAD);
               data_out[23 - 4*k -: 4] = buf_q[v_addr[k]];
            end
         end
      end
   end

   assign busy       = (state_q == RUN);
   assign done       = done_q;
   assign wr_full    = full_q;
   assign msg_len    = len_q;
   assign step_pulse = step_hit;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
module tb_seg_scroll_ctrl;

   localparam int STEP  = 4;
   localparam int MAXL  = 16;
   localparam logic [23:0] ALL_BLANK = 24'h555555;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_data;
   logic        clr;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic [23:0] data_out;
   logic        busy;
   logic        done;
   logic        wr_full;
   logic [4:0]  msg_len;
   logic        step_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   // reference copy of the stored message
   int model_msg[$];

   seg_scroll_ctrl #(
      .STEP_CYCLES(STEP),
      .MAX_LEN    (MAXL),
      .LEN_W      (5),
      .BLANK_CODE (4'd5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .clr       (clr),
      .start     (start),
      .stop      (stop),
      .loop_en   (loop_en),
      .data_out  (data_out),
      .busy      (busy),
      .done      (done),
      .wr_full   (wr_full),
      .msg_len   (msg_len),
      .step_pulse(step_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected display for window position p: pad the message with six
   // blanks on each side and take six consecutive symbols.
   function automatic logic [23:0] frame(input int p);
      int v[$];
      logic [23:0] r;
      for (int i = 0; i < 6; i++) v.push_back(5);
      foreach (model_msg[i]) v.push_back(model_msg[i]);
      for (int i = 0; i < 6; i++) v.push_back(5);
      r = '0;
      for (int k = 0; k < 6; k++) r = (r << 4) | 24'(v[p + k]);
      return r;
   endfunction

   task automatic do_write(input logic [3:0] code);
      wr_en   = 1'b1;
      wr_data = code;
      tick();
      wr_en   = 1'b0;
      if (model_msg.size() < MAXL) model_msg.push_back(int'(code));
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      model_msg.delete();
   endtask

   // Start a scroll and check every cycle against the time-based model.
   // Single pass: runs through the done pulse. Loop: runs ncyc cycles and
   // returns still scrolling.
   task automatic run_scroll(input bit lp, input int ncyc, input bit noise);
      int L, total, f, p;
      L = model_msg.size();
      total = lp ? ncyc : (L + 7) * STEP;
      loop_en = lp;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < total; t++) begin
         f = t / STEP;
         if (f <= L + 6) p = f;
         else p = 1 + (f - (L + 7)) % (L + 6);
         n_checks++;
         if (data_out !== frame(p)) begin
            n_fail++;
            $display("FAIL scroll_frame t=%0d p=%0d: got %h expected %h", t, p, data_out, frame(p));
         end
         n_checks++;
         if (step_pulse !== ((t % STEP) == STEP - 1)) begin
            n_fail++;
            $display("FAIL step_pulse t=%0d: got %b expected %b", t, step_pulse, (t % STEP) == STEP - 1);
         end
         n_checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL run_flags t=%0d: got busy=%b done=%b expected busy=1 done=0", t, busy, done);
         end
         if (noise) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_data = 4'($urandom_range(0, 15));
            clr     = ($urandom_range(0, 3) == 0);
            start   = 1'($urandom_range(0, 1));
         end
         tick();
      end
      wr_en = 1'b0;
      clr   = 1'b0;
      start = 1'b0;
      if (!lp) begin
         n_checks++;
         if (done !== 1'b1 || busy !== 1'b0 || data_out !== ALL_BLANK) begin
            n_fail++;
            $display("FAIL done_edge: got done=%b busy=%b data=%h expected done=1 busy=0 data=%h",
                     done, busy, data_out, ALL_BLANK);
         end
         tick();
         n_checks++;
         if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: got done=%b expected 0", done);
         end
      end
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if (data_out !== ALL_BLANK || busy !== 1'b0 || done !== 1'b0 || msg_len !== 5'd0
          || wr_full !== 1'b0 || step_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: got data=%h busy=%b done=%b len=%0d full=%b step=%b expected 555555/0/0/0/0/0",
                  data_out, busy, done, msg_len, wr_full, step_pulse);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (data_out !== ALL_BLANK || busy !== 1'b0 || msg_len !== 5'd0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got data=%h busy=%b len=%0d expected 555555/0/0", data_out, busy, msg_len);
      end
   endtask

   task automatic test_reset_mid_run();
      do_clr();
      for (int i = 0; i < 5; i++) do_write(4'(i));
      run_scroll(1'b1, 30, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      model_msg.delete();
      n_checks++;
      if (data_out !== ALL_BLANK || busy !== 1'b0 || done !== 1'b0 || msg_len !== 5'd0 || step_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_run: got data=%h busy=%b done=%b len=%0d step=%b expected 555555/0/0/0/0",
                  data_out, busy, done, msg_len, step_pulse);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got done=%b busy=%b expected 0/0", done, busy);
         end
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_pass();
      do_clr();
      for (int i = 0; i < 5; i++) do_write(4'(i));
      n_checks++;
      if (msg_len !== 5'd5) begin
         n_fail++;
         $display("FAIL hello_len: got %0d expected 5", msg_len);
      end
      run_scroll(1'b0, 0, 1'b0);
   endtask

   task automatic test_loop();
      int L;
      L = model_msg.size();
      run_scroll(1'b1, (L + 7) * STEP + 2 * (L + 6) * STEP + 6, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || data_out !== ALL_BLANK || done !== 1'b0) begin
         n_fail++;
         $display("FAIL loop_stop: got busy=%b data=%h done=%b expected 0/555555/0", busy, data_out, done);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || msg_len !== 5'(L)) begin
         n_fail++;
         $display("FAIL stop_keeps_msg: got done=%b len=%0d expected 0/%0d", done, msg_len, L);
      end
   endtask

   task automatic test_buffer();
      do_clr();
      for (int i = 0; i < 17; i++) begin
         do_write(4'($urandom_range(0, 15)));
         n_checks++;
         if (msg_len !== 5'(model_msg.size()) || wr_full !== (model_msg.size() == MAXL)) begin
            n_fail++;
            $display("FAIL fill_len i=%0d: got len=%0d full=%b expected len=%0d full=%b",
                     i, msg_len, wr_full, model_msg.size(), model_msg.size() == MAXL);
         end
      end
      // frames prove the 17th symbol did not land anywhere
      run_scroll(1'b0, 0, 1'b0);
      clr = 1'b1;
      wr_en = 1'b1;
      wr_data = 4'h3;
      tick();
      clr = 1'b0;
      wr_en = 1'b0;
      model_msg.delete();
      n_checks++;
      if (msg_len !== 5'd0 || wr_full !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_wins: got len=%0d full=%b expected 0/0", msg_len, wr_full);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (busy !== 1'b0 || data_out !== ALL_BLANK) begin
            n_fail++;
            $display("FAIL empty_start: got busy=%b data=%h expected 0/555555", busy, data_out);
         end
         tick();
      end
   endtask

   task automatic test_ignored_in_run();
      do_clr();
      for (int i = 0; i < 5; i++) do_write(4'($urandom_range(0, 15)));
      run_scroll(1'b0, 0, 1'b1);
      n_checks++;
      if (msg_len !== 5'd5) begin
         n_fail++;
         $display("FAIL run_ignores_writes: got len=%0d expected 5", msg_len);
      end
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_stop_idle: got busy=%b expected 0", busy);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0 || data_out !== ALL_BLANK) begin
         n_fail++;
         $display("FAIL start_stop_idle2: got busy=%b data=%h expected 0/555555", busy, data_out);
      end
   endtask

   task automatic test_min_len();
      do_clr();
      do_write(4'd4);
      run_scroll(1'b0, 0, 1'b0);
   endtask

   task automatic test_random();
      int L;
      for (int it = 0; it < 4; it++) begin
         do_clr();
         L = $urandom_range(1, MAXL);
         for (int i = 0; i < L; i++) do_write(4'($urandom_range(0, 15)));
         n_checks++;
         if (msg_len !== 5'(L)) begin
            n_fail++;
            $display("FAIL rand_len it=%0d: got %0d expected %0d", it, msg_len, L);
         end
         run_scroll(1'b0, 0, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = 4'h0;
      clr     = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      loop_en = 1'b0;

      test_reset();
      test_single_pass();
      test_loop();
      test_reset_mid_run();
      test_buffer();
      test_ignored_in_run();
      test_min_len();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
